// File: rtl/usr_seq_if.sv
// Command channel between a bus-side requester and the shift-register
// sequencer.
//   cmd_valid : command present (requester -> controller)
//   cmd_ready : controller can accept a command (controller -> requester)
//   cmd_op    : 00 NOP, 01 shift left, 10 shift right, 11 load then shift left
//   cmd_len   : requested number of shift cycles
//   cmd_data  : parallel word used by op 11
interface usr_seq_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a WIDTH-bit universal shift register. Takes one
// command at a time over the cmd channel and drives the register's mode
// select and parallel-load word cycle by cycle.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   cmd       : command channel (slave side), see usr_seq_if
//   abort     : synchronous abort of the running command (LOAD/SHIFT only)
//   usr_sel   : datapath mode, 00 hold, 01 shl, 10 shr, 11 parallel load
//   usr_pi    : parallel-load word, meaningful only while usr_sel = 11
//   busy      : high in LOAD or SHIFT
//   remaining : shift cycles still to issue, counting the current one
//   done      : one-cycle pulse on normal completion
module usr_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  usr_seq_if.slave         cmd,
  input  logic             abort,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_pi,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

  state_t           state, state_n;
  logic [1:0]       op_q, op_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [CNT_W-1:0] len_eff;
  logic             ready;
  logic             accept;

  // Ready is masked by rst so the requester sees it low for the whole reset.
  assign ready         = (state == IDLE) && !rst;
  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid && ready;

  always_comb begin
    len_eff = cmd.cmd_len;
    if (cmd.cmd_len > LEN_MAX) len_eff = LEN_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      cnt_q  <= cnt_n;
      data_q <= data_n;
    end
  end

  // Next state. cnt_q holds the count before the current cycle's shift, so
  // the SHIFT cycle that sees cnt_q == 1 is the last one.
  always_comb begin
    state_n = state;
    op_n    = op_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          op_n  = cmd.cmd_op;
          cnt_n = len_eff;
          if (cmd.cmd_op == 2'b11) begin
            data_n  = cmd.cmd_data;
            state_n = LOAD;
          end else if (cmd.cmd_op != 2'b00 && len_eff != '0) begin
            state_n = SHIFT;
          end else begin
            state_n = DONE;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q != '0) begin
          state_n = SHIFT;
        end else begin
          state_n = DONE;
        end
      end
      SHIFT: begin
        cnt_n = cnt_q - 1'b1;
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    usr_sel   = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    remaining = '0;
    unique case (state)
      LOAD: begin
        usr_sel   = 2'b11;
        busy      = 1'b1;
        remaining = cnt_q;
      end
      SHIFT: begin
        usr_sel   = (op_q == 2'b10) ? 2'b10 : 2'b01;
        busy      = 1'b1;
        remaining = cnt_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        usr_sel = 2'b00;
      end
    endcase
  end

  assign usr_pi = data_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Scoreboard bench for usr_seq_ctrl: the driver pushes the expected per-cycle
// outputs of each accepted command; the monitor pops one entry per cycle and
// checks idle/reset outputs when nothing is queued.
module tb_usr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort;
  logic [1:0] usr_sel;
  logic [4:0] usr_pi;
  logic       busy;
  logic [2:0] remaining;
  logic       done;

  usr_seq_if #(.WIDTH(5), .CNT_W(3)) bus ();

  usr_seq_ctrl #(.WIDTH(5), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus),
    .abort     (abort),
    .usr_sel   (usr_sel),
    .usr_pi    (usr_pi),
    .busy      (busy),
    .remaining (remaining),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [4:0] pi;
    logic [2:0] rem;
    logic       busy;
    logic       done;
    logic       ready;
  } obs_t;

  obs_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] last_pi = 5'b0;

  function automatic obs_t mk(input logic [1:0] sel, input logic [4:0] pi,
                              input logic [2:0] rem, input logic b,
                              input logic d, input logic r);
    obs_t o;
    o.sel = sel; o.pi = pi; o.rem = rem; o.busy = b; o.done = d; o.ready = r;
    return o;
  endfunction

  function automatic void check(input obs_t e, input string tag);
    obs_t a;
    a = mk(usr_sel, usr_pi, remaining, busy, done, bus.cmd_ready);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got sel=%b pi=%b rem=%0d busy=%b done=%b rdy=%b, exp sel=%b pi=%b rem=%0d busy=%b done=%b rdy=%b",
               tag, $time, a.sel, a.pi, a.rem, a.busy, a.done, a.ready,
               e.sel, e.pi, e.rem, e.busy, e.done, e.ready);
    end
  endfunction

  // Monitor: one observation per cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst)
      check(mk(2'b00, 5'b0, 3'd0, 1'b0, 1'b0, 1'b0), "reset");
    else if (q.size() > 0)
      check(q.pop_front(), "seq");
    else
      check(mk(2'b00, last_pi, 3'd0, 1'b0, 1'b0, 1'b1), "idle");
  end

  // Reset must clear outputs before any clock edge.
  always @(posedge rst) begin
    #1;
    check(mk(2'b00, 5'b0, 3'd0, 1'b0, 1'b0, 1'b0), "async_rst");
  end

  // Expected cycles after an accept edge; abort_at = post-accept cycle
  // (1-based) during which abort is held high, 0 for none.
  task automatic push_cmd(input logic [1:0] op, input logic [2:0] len,
                          input logic [4:0] data, input int abort_at);
    int         c;
    logic [2:0] leff;
    logic [1:0] sh;
    obs_t       idle_e;
    c    = 0;
    leff = (len > 3'd5) ? 3'd5 : len;
    sh   = (op == 2'b10) ? 2'b10 : 2'b01;
    if (op == 2'b11) begin
      last_pi = data;
      c++;
      q.push_back(mk(2'b11, last_pi, leff, 1'b1, 1'b0, 1'b0));
      if (c == abort_at) begin
        q.push_back(mk(2'b00, last_pi, 3'd0, 1'b0, 1'b0, 1'b1));
        return;
      end
    end
    if (op != 2'b00) begin
      for (int r = int'(leff); r > 0; r--) begin
        c++;
        q.push_back(mk(sh, last_pi, 3'(r), 1'b1, 1'b0, 1'b0));
        if (c == abort_at) begin
          q.push_back(mk(2'b00, last_pi, 3'd0, 1'b0, 1'b0, 1'b1));
          return;
        end
      end
    end
    idle_e = mk(2'b00, last_pi, 3'd0, 1'b0, 1'b0, 1'b1);
    q.push_back(mk(2'b00, last_pi, 3'd0, 1'b0, 1'b1, 1'b0));
    q.push_back(idle_e);
  endtask

  // Returns just after the accepting edge.
  task automatic wait_accept();
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout @%0t: cmd_ready=%b, required 1", $time, bus.cmd_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout @%0t: %0d entries left, required 0", $time, q.size());
      q.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] len,
                       input logic [4:0] data, input int abort_at);
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    wait_accept();
    push_cmd(op, len, data, abort_at);
    // Fields are free to change once accepted.
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'(op + 2'd1);
    bus.cmd_len   = 3'(len + 3'd3);
    bus.cmd_data  = ~data;
    if (abort_at > 0) begin
      repeat (abort_at - 1) begin
        @(posedge clk);
        #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = 3'd0;
    bus.cmd_data  = 5'b0;
    abort         = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;

    issue(2'b11, 3'd3, 5'b10110, 0);  // load then shift left
    issue(2'b10, 3'd7, 5'b11111, 0);  // shift right, clamped to 5
    issue(2'b01, 3'd0, 5'b00001, 0);  // zero length
    issue(2'b00, 3'd4, 5'b00011, 0);  // NOP
    issue(2'b01, 3'd5, 5'b00000, 2);  // abort in 2nd SHIFT cycle
    issue(2'b00, 3'd0, 5'b00000, 1);  // abort during DONE is ignored
    issue(2'b11, 3'd0, 5'b01011, 0);  // load only
    issue(2'b11, 3'd6, 5'b10001, 1);  // abort in LOAD

    // cmd_valid held high with alternating ops while busy
    bus.cmd_len   = 3'd2;
    bus.cmd_data  = 5'b0;
    bus.cmd_op    = 2'b01;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept();
      push_cmd(bus.cmd_op, 3'd2, 5'b0, 0);
      bus.cmd_op = (bus.cmd_op == 2'b01) ? 2'b10 : 2'b01;
    end
    bus.cmd_valid = 1'b0;
    drain();

    // asynchronous reset mid-SHIFT with remaining = 3
    bus.cmd_op    = 2'b01;
    bus.cmd_len   = 3'd5;
    bus.cmd_valid = 1'b1;
    wait_accept();
    push_cmd(2'b01, 3'd5, 5'b0, 0);
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    last_pi = 5'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    issue(2'b10, 3'd1, 5'b01010, 0);  // usr_pi cleared by reset, op 10 keeps it

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
